// File: rtl/tpu_fp_pkg.sv
// Shared FP32 types and constants for the TPU activation path.
// Also holds the compact FP32 add/multiply used by the series stepper.
package tpu_fp_pkg;

  typedef logic [31:0] fp32_t;

  localparam fp32_t      FP32_ONE     = 32'h3F800000;
  localparam fp32_t      FP32_ZERO    = 32'h0;
  localparam fp32_t      FP32_QNAN    = 32'h7FC00000;
  localparam logic [7:0] FP32_EXP_MAX = 8'hFF;

  typedef enum logic {
    SER_FACT,
    SER_POW
  } ser_mode_e;

  // Round-to-nearest-even; subnormals flush to zero.
  function automatic fp32_t fp_add(input fp32_t a, input fp32_t b);
    fp32_t             hi, lo;
    logic [27:0]       mh, ml, s;
    logic [7:0]        sh;
    logic signed [9:0] e;
    logic [24:0]       mr;
    logic              rnd;
    if (a[30:0] >= b[30:0]) begin
      hi = a;
      lo = b;
    end else begin
      hi = b;
      lo = a;
    end
    if (hi[30:23] == FP32_EXP_MAX || lo[30:23] == 8'h00)
      return hi;
    sh = hi[30:23] - lo[30:23];
    mh = {2'b01, hi[22:0], 3'b000};
    ml = {2'b01, lo[22:0], 3'b000};
    if (sh > 8'd26)
      ml = 28'd1;
    else
      ml = (ml >> sh)
         | {27'd0, |(ml & ((28'd1 << sh) - 28'd1))};
    s = (hi[31] == lo[31]) ? mh + ml : mh - ml;
    if (s == 28'd0)
      return FP32_ZERO;
    e = $signed({2'b00, hi[30:23]});
    if (s[27]) begin
      s = {1'b0, s[27:2], s[1] | s[0]};
      e = e + 10'sd1;
    end
    for (int i = 0; i < 26; i++) begin
      if (!s[26]) begin
        s = s << 1;
        e = e - 10'sd1;
      end
    end
    rnd = s[2] & (s[1] | s[0] | s[3]);
    mr  = {1'b0, s[26:3]} + {24'd0, rnd};
    if (mr[24]) begin
      mr = mr >> 1;
      e  = e + 10'sd1;
    end
    if (e >= 10'sd255)
      return {hi[31], FP32_EXP_MAX, 23'd0};
    if (e <= 10'sd0)
      return {hi[31], 31'd0};
    return {hi[31], e[7:0], mr[22:0]};
  endfunction

  function automatic fp32_t fp_mul(input fp32_t a, input fp32_t b);
    logic              sgn, g, st, rnd;
    logic              a_zero, b_zero, a_spec, b_spec;
    logic [47:0]       p;
    logic [23:0]       m;
    logic signed [9:0] e;
    logic [24:0]       mr;
    sgn    = a[31] ^ b[31];
    a_zero = a[30:23] == 8'h00;
    b_zero = b[30:23] == 8'h00;
    a_spec = a[30:23] == FP32_EXP_MAX;
    b_spec = b[30:23] == FP32_EXP_MAX;
    if ((a_spec && a[22:0] != 23'd0) ||
        (b_spec && b[22:0] != 23'd0) ||
        (a_spec && b_zero) || (b_spec && a_zero))
      return FP32_QNAN;
    if (a_spec || b_spec)
      return {sgn, FP32_EXP_MAX, 23'd0};
    if (a_zero || b_zero)
      return {sgn, 31'd0};
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = $signed({2'b00, a[30:23]})
      + $signed({2'b00, b[30:23]}) - 10'sd127;
    if (p[47]) begin
      m  = p[47:24];
      g  = p[23];
      st = |p[22:0];
      e  = e + 10'sd1;
    end else begin
      m  = p[46:23];
      g  = p[22];
      st = |p[21:0];
    end
    rnd = g & (st | m[0]);
    mr  = {1'b0, m} + {24'd0, rnd};
    if (mr[24]) begin
      mr = mr >> 1;
      e  = e + 10'sd1;
    end
    if (e >= 10'sd255)
      return {sgn, FP32_EXP_MAX, 23'd0};
    if (e <= 10'sd0)
      return {sgn, 31'd0};
    return {sgn, e[7:0], mr[22:0]};
  endfunction

endpackage

// File: rtl/fp_series_step.sv
// One combinational series step: count+1 and acc*(x or count+1).
// Single adder and single multiplier shared by both modes.
module fp_series_step
  import tpu_fp_pkg::*;
(
  input  ser_mode_e mode,
  input  fp32_t     x,
  input  fp32_t     acc,
  input  fp32_t     count,
  output fp32_t     next_count,
  output fp32_t     next_acc
);

  fp32_t mul_b;

  assign next_count = fp_add(count, FP32_ONE);
  assign mul_b      = (mode == SER_POW) ? x : next_count;
  assign next_acc   = fp_mul(acc, mul_b);

endmodule

// File: rtl/fp_series_gen.sv
// Streams FP32 factorial or power terms 0..n over a valid/ready port.
// Registers and FSM only; arithmetic lives in fp_series_step.
module fp_series_gen
  import tpu_fp_pkg::*;
#(
  parameter  int MAX_N = 30,
  localparam int IDX_W = $clog2(MAX_N + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [IDX_W-1:0] n_i,
  input  logic             mode_i,
  input  logic [31:0]      x_i,
  output logic             busy_o,
  output logic             term_valid_o,
  input  logic             term_ready_i,
  output logic [31:0]      term_o,
  output logic [IDX_W-1:0] term_idx_o,
  output logic             last_o,
  output logic             overflow_o,
  output logic             done_o
);

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    DONE
  } state_e;

  state_e           state;
  ser_mode_e        mode_q;
  fp32_t            x_q;
  fp32_t            acc;
  fp32_t            count;
  fp32_t            next_count;
  fp32_t            next_acc;
  logic [IDX_W-1:0] n_q;
  logic [IDX_W-1:0] n_eff;
  logic [IDX_W-1:0] idx_nxt;
  logic             hs;

  assign n_eff = (n_i > IDX_W'(MAX_N)) ? IDX_W'(MAX_N) : n_i;
  assign hs      = term_valid_o & term_ready_i;
  assign idx_nxt = term_idx_o + IDX_W'(1);
  assign term_o  = acc;

  fp_series_step u_step (
    .mode       (mode_q),
    .x          (x_q),
    .acc        (acc),
    .count      (count),
    .next_count (next_count),
    .next_acc   (next_acc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      mode_q       <= SER_FACT;
      x_q          <= '0;
      n_q          <= '0;
      acc          <= '0;
      count        <= '0;
      term_idx_o   <= '0;
      last_o       <= 1'b0;
      term_valid_o <= 1'b0;
      busy_o       <= 1'b0;
      overflow_o   <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_i) begin
            mode_q       <= ser_mode_e'(mode_i);
            x_q          <= x_i;
            n_q          <= n_eff;
            acc          <= FP32_ONE;
            count        <= FP32_ZERO;
            term_idx_o   <= '0;
            last_o       <= (n_eff == '0);
            term_valid_o <= 1'b1;
            busy_o       <= 1'b1;
            overflow_o   <= 1'b0;
            state        <= EMIT;
          end
        end
        EMIT: begin
          if (hs && last_o) begin
            term_valid_o <= 1'b0;
            busy_o       <= 1'b0;
            last_o       <= 1'b0;
            done_o       <= 1'b1;
            state        <= DONE;
          end else if (hs) begin
            acc        <= next_acc;
            count      <= next_count;
            term_idx_o <= idx_nxt;
            last_o     <= (idx_nxt == n_q);
            // flag rises together with the inf/NaN term it describes
            if (next_acc[30:23] == FP32_EXP_MAX)
              overflow_o <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_series_gen.sv
// Directed bench for fp_series_gen: factorial, power, overflow,
// clamping, stalls, ignored start and mid-stream reset.
module tb_fp_series_gen;

  localparam int MAX_N = 30;
  localparam int IDX_W = $clog2(MAX_N + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start_i = 1'b0;
  logic [IDX_W-1:0] n_i = '0;
  logic             mode_i = 1'b0;
  logic [31:0]      x_i = '0;
  logic             term_ready_i = 1'b0;
  logic             busy_o;
  logic             term_valid_o;
  logic [31:0]      term_o;
  logic [IDX_W-1:0] term_idx_o;
  logic             last_o;
  logic             overflow_o;
  logic             done_o;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  fp_series_gen #(.MAX_N(MAX_N)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .n_i          (n_i),
    .mode_i       (mode_i),
    .x_i          (x_i),
    .busy_o       (busy_o),
    .term_valid_o (term_valid_o),
    .term_ready_i (term_ready_i),
    .term_o       (term_o),
    .term_idx_o   (term_idx_o),
    .last_o       (last_o),
    .overflow_o   (overflow_o),
    .done_o       (done_o)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_valid"}, 32'(term_valid_o), 32'd0);
    chk({tag, "_term"}, term_o, 32'd0);
    chk({tag, "_idx"}, 32'(term_idx_o), 32'd0);
    chk({tag, "_last"}, 32'(last_o), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow_o), 32'd0);
    chk({tag, "_done"}, 32'(done_o), 32'd0);
  endtask

  task automatic do_start(input logic m, input logic [31:0] x,
                          input logic [IDX_W-1:0] n);
    @(negedge clk);
    start_i = 1'b1;
    mode_i  = m;
    x_i     = x;
    n_i     = n;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // Consumes nterms terms; values checked for the first exp_q.size().
  task automatic run_stream(input int nterms, input bit stall);
    int               k = 0;
    int               cyc = 0;
    logic             ovf = 1'b0;
    logic             held = 1'b0;
    logic             r;
    logic [31:0]      h_term = '0;
    logic [IDX_W-1:0] h_idx = '0;
    logic             h_last = 1'b0;
    while (k < nterms && cyc < 400) begin
      if (held) begin
        chk("stall_term", term_o, h_term);
        chk("stall_idx", 32'(term_idx_o), 32'(h_idx));
        chk("stall_last", 32'(last_o), 32'(h_last));
      end
      chk("valid", 32'(term_valid_o), 32'd1);
      chk("busy", 32'(busy_o), 32'd1);
      chk("done_in_stream", 32'(done_o), 32'd0);
      r = stall ? (cyc[0] == 1'b0) : 1'b1;
      if (r) begin
        if (k < exp_q.size()) begin
          chk("term", term_o, exp_q[k]);
          if (exp_q[k][30:23] == 8'hFF) ovf = 1'b1;
        end
        chk("idx", 32'(term_idx_o), 32'(k));
        chk("last", 32'(last_o), 32'(k == nterms - 1));
        chk("ovf", 32'(overflow_o), 32'(ovf));
        k++;
        held = 1'b0;
      end else begin
        held   = 1'b1;
        h_term = term_o;
        h_idx  = term_idx_o;
        h_last = last_o;
      end
      term_ready_i = r;
      @(negedge clk);
      cyc++;
    end
    term_ready_i = 1'b0;
    if (k < nterms) chk("stream_timeout", 32'(k), 32'(nterms));
    chk("done_pulse", 32'(done_o), 32'd1);
    chk("valid_at_done", 32'(term_valid_o), 32'd0);
    chk("busy_at_done", 32'(busy_o), 32'd0);
    chk("ovf_at_done", 32'(overflow_o), 32'(ovf));
    @(negedge clk);
    chk("done_clear", 32'(done_o), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    exp_q = '{32'h3F800000, 32'h3F800000, 32'h40000000,
              32'h40C00000, 32'h41C00000, 32'h42F00000};
    do_start(1'b0, 32'h0, 5'd5);
    run_stream(6, 1'b0);

    exp_q = '{32'h3F800000, 32'h40000000, 32'h40800000, 32'h41000000};
    do_start(1'b1, 32'h40000000, 5'd3);
    run_stream(4, 1'b1);

    exp_q = '{32'h3F800000, 32'h7F000000, 32'h7F800000};
    do_start(1'b1, 32'h7F000000, 5'd2);
    run_stream(3, 1'b0);

    exp_q = '{32'h3F800000};
    do_start(1'b0, 32'h0, 5'd0);
    run_stream(1, 1'b0);

    exp_q = '{32'h3F800000, 32'h3F800000, 32'h40000000,
              32'h40C00000, 32'h41C00000, 32'h42F00000};
    do_start(1'b0, 32'h0, 5'(MAX_N + 1));
    run_stream(MAX_N + 1, 1'b0);

    // mid-stream start is ignored, then reset at idx 3
    do_start(1'b0, 32'h0, 5'd10);
    term_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("ms_idx", 32'(term_idx_o), 32'(k));
      chk("ms_term", term_o, exp_q[k]);
      chk("ms_valid", 32'(term_valid_o), 32'd1);
      start_i = (k == 1);
      mode_i  = 1'b1;
      n_i     = 5'd0;
      if (k < 3) @(negedge clk);
    end
    start_i      = 1'b0;
    term_ready_i = 1'b0;
    rst          = 1'b1;
    #1;
    chk_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    chk_zero("after_rst");

    exp_q = '{32'h3F800000, 32'h40400000, 32'h41100000};
    do_start(1'b1, 32'h40400000, 5'd2);
    run_stream(3, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
